// File: rtl/pcf8574_target_pkg.sv
// Shared types for the PCF8574 I2C target: FSM states and bit-counter width.
package pcf8574_target_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one raw I2C line: 2-flop synchronizer, stability filter and
// one-cycle rise/fall pulses registered together with the filtered level.
module i2c_line_cond #(
  parameter int FILTER = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Idle bus lines are high, so the conditioned level starts high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcf8574_target.sv
// I2C target emulating a PCF8574 8-bit port expander: writes drive port_out,
// reads return a snapshot of port_in.
module pcf8574_target
  import pcf8574_target_pkg::*;
#(
  parameter logic [7:0] ADDR   = 8'h40,
  parameter int         FILTER = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       write_strobe,
  output logic       read_strobe,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  state_t           state;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             byte_full;

  i2c_line_cond #(.FILTER(FILTER)) u_scl (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (scl_in),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_cond #(.FILTER(FILTER)) u_sda (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (sda_in),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  // The 3-bit counter wraps to 0 after eight bits, so byte_full marks a
  // completed byte and keeps the post-START SCL fall from looking like one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      byte_full    <= 1'b0;
      sda_oe       <= 1'b0;
      port_out     <= 8'hFF;
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      if (stop_det) begin
        state     <= ST_IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        byte_full <= 1'b0;
      end else if (start_det) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        byte_full <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          ST_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 1'b1;
              if (&bit_cnt) byte_full <= 1'b1;
            end else if (scl_fall && byte_full) begin
              byte_full <= 1'b0;
              if (state == ST_WR_DATA) begin
                sda_oe <= 1'b1;
                state  <= ST_WR_ACK;
              end else if (shreg[7:1] == ADDR[7:1]) begin
                sda_oe <= 1'b1;
                state  <= ST_ADDR_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (shreg[0]) begin
                shreg       <= port_in;
                read_strobe <= 1'b1;
                sda_oe      <= ~port_in[7];
                state       <= ST_RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WR_DATA;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              port_out     <= shreg;
              write_strobe <= 1'b1;
              sda_oe       <= 1'b0;
              bit_cnt      <= '0;
              state        <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (&bit_cnt) byte_full <= 1'b1;
            end else if (scl_fall) begin
              if (byte_full) begin
                byte_full <= 1'b0;
                sda_oe    <= 1'b0;
                state     <= ST_RD_ACK;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          ST_RD_ACK: begin
            // A NACK ends the read; an ACK reloads port_in on the following fall.
            if (scl_rise && sda_lvl) begin
              state <= ST_IGNORE;
            end else if (scl_fall) begin
              shreg       <= port_in;
              read_strobe <= 1'b1;
              sda_oe      <= ~port_in[7];
              bit_cnt     <= '0;
              state       <= ST_RD_DATA;
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcf8574_target.sv
// Directed bench for pcf8574_target: a bit-banged I2C master with hand-computed
// expectations for writes, reads, address mismatch, aborts, glitches and reset.
module tb_pcf8574_target;

  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] port_in = 8'h00;
  logic       sda_oe;
  logic [7:0] port_out;
  logic       write_strobe;
  logic       read_strobe;
  logic       busy;
  logic       sda_line;

  int errors = 0;
  int checks = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int oe_cycles = 0;

  assign sda_line = sda_m & ~sda_oe;

  pcf8574_target #(.ADDR(8'h40), .FILTER(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_oe       (sda_oe),
    .port_in      (port_in),
    .port_out     (port_out),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Running tallies; tests look at the change across a scenario.
  always @(posedge clk) begin
    if (write_strobe) wr_pulses++;
    if (read_strobe) rd_pulses++;
    if (sda_oe) oe_cycles++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b0; wait_clk(H);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    scl_m = 1'b0; wait_clk(H);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    b = sda_line;
    scl_m = 1'b0; wait_clk(H);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  task automatic send_ack(input logic ack);
    write_bit(~ack);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (port_out !== 8'hFF) begin errors++; $display("[TB] FAIL reset_port_out: got %h expected ff", port_out); end
    checks++; if (write_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_strobe: got %b expected 0", write_strobe); end
    checks++; if (read_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_strobe: got %b expected 0", read_strobe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_no_match;
    logic ack;
    int oe0, wr0;
    oe0 = oe_cycles; wr0 = wr_pulses;
    i2c_start;
    write_byte(8'h42, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL nomatch_addr_ack: got %b expected 0", ack); end
    write_byte(8'h00, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL nomatch_data_ack: got %b expected 0", ack); end
    i2c_stop;
    checks++; if (oe_cycles - oe0 != 0) begin errors++; $display("[TB] FAIL nomatch_oe_cycles: got %0d expected 0", oe_cycles - oe0); end
    checks++; if (port_out !== 8'hFF) begin errors++; $display("[TB] FAIL nomatch_port_out: got %h expected ff", port_out); end
    checks++; if (wr_pulses - wr0 != 0) begin errors++; $display("[TB] FAIL nomatch_write_strobes: got %0d expected 0", wr_pulses - wr0); end
  endtask

  task automatic test_write_single;
    logic ack;
    int wr0;
    wr0 = wr_pulses;
    i2c_start;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy_after_start: got %b expected 1", busy); end
    write_byte(8'h40, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL write_addr_ack: got %b expected 1", ack); end
    write_byte(8'hA5, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL write_data_ack: got %b expected 1", ack); end
    i2c_stop;
    checks++; if (port_out !== 8'hA5) begin errors++; $display("[TB] FAIL write_port_out: got %h expected a5", port_out); end
    checks++; if (wr_pulses - wr0 != 1) begin errors++; $display("[TB] FAIL write_strobes: got %0d expected 1", wr_pulses - wr0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_read_nack;
    logic ack;
    logic [7:0] d;
    int rd0, oe0;
    rd0 = rd_pulses;
    port_in = 8'h3C;
    i2c_start;
    write_byte(8'h41, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL read_addr_ack: got %b expected 1", ack); end
    read_byte(d);
    checks++; if (d !== 8'h3C) begin errors++; $display("[TB] FAIL read_data: got %h expected 3c", d); end
    oe0 = oe_cycles;
    send_ack(1'b0);
    i2c_stop;
    checks++; if (oe_cycles - oe0 != 0) begin errors++; $display("[TB] FAIL read_oe_after_nack: got %0d expected 0", oe_cycles - oe0); end
    checks++; if (rd_pulses - rd0 != 1) begin errors++; $display("[TB] FAIL read_strobes: got %0d expected 1", rd_pulses - rd0); end
    checks++; if (port_out !== 8'hA5) begin errors++; $display("[TB] FAIL read_port_out_kept: got %h expected a5", port_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL read_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic ack;
    logic [7:0] d1, d2;
    int wr0, rd0;
    wr0 = wr_pulses; rd0 = rd_pulses;
    i2c_start;
    write_byte(8'h40, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_addr_ack: got %b expected 1", ack); end
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_data_ack: got %b expected 1", ack); end
    checks++; if (wr_pulses - wr0 != 2) begin errors++; $display("[TB] FAIL b2b_write_strobes: got %0d expected 2", wr_pulses - wr0); end
    checks++; if (port_out !== 8'h22) begin errors++; $display("[TB] FAIL b2b_port_out: got %h expected 22", port_out); end
    port_in = 8'h80;
    i2c_start;
    write_byte(8'h41, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rd_addr_ack: got %b expected 1", ack); end
    read_byte(d1);
    port_in = 8'h01;
    send_ack(1'b1);
    read_byte(d2);
    send_ack(1'b0);
    i2c_stop;
    checks++; if (d1 !== 8'h80) begin errors++; $display("[TB] FAIL b2b_read_first: got %h expected 80", d1); end
    checks++; if (d2 !== 8'h01) begin errors++; $display("[TB] FAIL b2b_read_second: got %h expected 01", d2); end
    checks++; if (rd_pulses - rd0 != 2) begin errors++; $display("[TB] FAIL b2b_read_strobes: got %0d expected 2", rd_pulses - rd0); end
  endtask

  task automatic test_partial_stop_glitch;
    logic ack;
    int wr0;
    wr0 = wr_pulses;
    i2c_start;
    write_byte(8'h40, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL abort_addr_ack: got %b expected 1", ack); end
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop;
    checks++; if (port_out !== 8'h22) begin errors++; $display("[TB] FAIL abort_port_out: got %h expected 22", port_out); end
    checks++; if (wr_pulses - wr0 != 0) begin errors++; $display("[TB] FAIL abort_write_strobes: got %0d expected 0", wr_pulses - wr0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    wr0 = wr_pulses;
    i2c_start;
    scl_m = 1'b1; wait_clk(1);
    scl_m = 1'b0; wait_clk(H);
    write_byte(8'h40, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL glitch_addr_ack: got %b expected 1", ack); end
    write_byte(8'h5A, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL glitch_data_ack: got %b expected 1", ack); end
    i2c_stop;
    checks++; if (port_out !== 8'h5A) begin errors++; $display("[TB] FAIL glitch_port_out: got %h expected 5a", port_out); end
    checks++; if (wr_pulses - wr0 != 1) begin errors++; $display("[TB] FAIL glitch_write_strobes: got %0d expected 1", wr_pulses - wr0); end
  endtask

  task automatic test_reset_mid_read;
    logic ack;
    port_in = 8'h00;
    i2c_start;
    write_byte(8'h41, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL rstread_addr_ack: got %b expected 1", ack); end
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("[TB] FAIL rstread_driving_msb: got %b expected 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL rstread_oe_drop: got %b expected 0", sda_oe); end
    checks++; if (port_out !== 8'hFF) begin errors++; $display("[TB] FAIL rstread_port_out: got %h expected ff", port_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstread_busy: got %b expected 0", busy); end
    wait_clk(3);
    rst_n = 1'b1;
    sda_m = 1'b1;
    scl_m = 1'b1;
    wait_clk(H);
    i2c_start;
    write_byte(8'h40, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL rstread_new_addr_ack: got %b expected 1", ack); end
    write_byte(8'h77, ack);
    i2c_stop;
    checks++; if (port_out !== 8'h77) begin errors++; $display("[TB] FAIL rstread_new_port_out: got %h expected 77", port_out); end
  endtask

  initial begin
    test_reset;
    test_no_match;
    test_write_single;
    test_read_nack;
    test_back_to_back;
    test_partial_stop_glitch;
    test_reset_mid_read;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcf8574_target.md
# pcf8574_target

I2C target (responder) emulating a PCF8574 8-bit quasi-bidirectional port expander. It sits on the I2C pins of a second FPGA or an on-chip loopback and answers the `expansion_pcf8574` master, which makes it both a board-level port-expander substitute and the bus-functional counterpart used to verify the master. Written bytes drive `port_out`; read bytes return a snapshot of `port_in`.

## Interface
- `ADDR`, 8'h40: 8-bit write-address byte; bit 0 ignored; matched against received bits [7:1].
- `FILTER`, 3: SCL/SDA glitch filter, in clk cycles; a line change must be stable this long to be accepted.
- `clk` input 1: system clock; sole clock domain.
- `rst_n` input 1: reset, asynchronous, active-low.
- `scl_in` input 1: raw SCL pin level (asynchronous).
- `sda_in` input 1: raw SDA pin level (asynchronous).
- `sda_oe` output 1: 1 = pull SDA low; the top level builds the open-drain buffer.
- `port_in` input 8: levels returned on reads.
- `port_out` output 8: last byte written by the master.
- `write_strobe` output 1: one-cycle pulse when `port_out` updates.
- `read_strobe` output 1: one-cycle pulse when `port_in` is captured for transmission.
- `busy` output 1: high from an accepted START to the next STOP.

## Operation
- Line conditioning: 2-flop synchronizer, then a `FILTER`-cycle stability filter, per line. The filtered levels yield `scl_rise`, `scl_fall`, START (SDA falls while SCL is high) and STOP (SDA rises while SCL is high).
- SDA is sampled on `scl_rise`. `sda_oe` changes only on `scl_fall`.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- START in any state goes to ADDR and clears the bit counter. A repeated START is therefore legal anywhere.
- STOP in any state goes to IDLE and forces `sda_oe`=0.
- ADDR: shift 8 bits MSB first.
  - On the 8th `scl_fall`, if bits [7:1] match `ADDR`[7:1], assert `sda_oe` and go to ADDR_ACK.
  - If they do not match, go to IGNORE with `sda_oe` left at 0.
- ADDR_ACK, on `scl_fall`:
  - R/W=0: release SDA and go to WR_DATA.
  - R/W=1: load the shift register with `port_in`, pulse `read_strobe`, drive the MSB (`sda_oe` = ~bit7) and go to RD_DATA.
- WR_DATA: shift 8 bits. On the 8th `scl_fall`, assert `sda_oe` (ACK) and go to WR_ACK.
- WR_ACK, on `scl_fall`: update `port_out` with the byte, pulse `write_strobe`, release SDA and return to WR_DATA. Any number of bytes may be written per transfer.
- RD_DATA: drive the next bit on each `scl_fall`. After the 8th bit, release SDA on `scl_fall` and go to RD_ACK.
- RD_ACK, sampled on `scl_rise`:
  - ACK (SDA=0): on `scl_fall`, recapture `port_in`, pulse `read_strobe`, drive the MSB and go to RD_DATA.
  - NACK: go to IGNORE.
- IGNORE: `sda_oe`=0. Wait for START or STOP.
- A STOP mid-byte discards the partial byte. `port_out` changes only in WR_ACK.

## Timing
- Reset values: `sda_oe`=0, `port_out`=8'hFF (PCF8574 power-up high), `write_strobe`=0, `read_strobe`=0, `busy`=0, state IDLE.
- Latency from pin change to event is 2 + `FILTER` + 1 clk. Each edge's outputs (`sda_oe`, strobes, `port_out`) register one clk after the event.
- Minimum SCL high and low times are `FILTER`+6 clk. Setup margin for the master is one SCL low phase, minus latency.
- `write_strobe` and `port_out` change in the same clk. `read_strobe` occurs in the clk where `port_in` is captured.
- Asynchronous reset mid-transfer: `sda_oe` drops immediately. After release the block stays in IDLE until the next START.

## Structure
- `pcf8574_target_pkg`: state enum and the bit-count width constant (3 bits, wraps 7→0 at the byte boundary).
- Sub-module `i2c_line_cond`, instantiated once per line: synchronizer, filter and rise/fall outputs. START/STOP decoding stays in the top module.
- Main FSM, 8-bit shift register and counter: roughly 200 lines.

## Test plan
- Address 0x40 plus byte 0xA5, then STOP: ACK low during both 9th clocks, `port_out`=0xA5, exactly one `write_strobe`, `busy` low after STOP.
- `port_in`=0x3C, read from 0x41 with master NACK: master receives 0x3C, exactly one `read_strobe`, `sda_oe`=0 from the NACK to the STOP.
- Address 0x42 with data 0x00: no ACK, `sda_oe` never asserted, `port_out` stays 0xFF.
- Write 0x11, 0x22 in one transfer: two `write_strobe` pulses, final `port_out`=0x22. Then a repeated START to 0x41 with `port_in`=0x80, ACK, `port_in`→0x01, NACK: bytes read are 0x80 then 0x01.
- STOP after 4 data bits of 0xF0: `port_out` unchanged, next transfer behaves normally. A 1-clk SCL glitch (shorter than `FILTER`) is ignored.
- `rst_n` low while `sda_oe`=1 mid-read: `sda_oe`=0 in the same cycle, `port_out`=0xFF, a new START then works.
